tick_sched: RTL

TICK_SCHED -- requirements
Module: tick_sched

---
 rtl/tick_sched_pkg.sv | 8 +
 rtl/tick_chan.sv | 43 ++++
 rtl/tick_sched.sv | 42 ++++
 3 files changed

// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg: shared defaults and the channel-index width helper for tick_sched
package tick_sched_pkg;
    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 32;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tick_chan.sv
// tick_chan: one divider channel with applied and pending configuration and a registered tick strobe
module tick_chan #(
    parameter int CNT_W = 32
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_en,
    output logic             tick,
    output logic             active,
    output logic             pending
);
    logic [CNT_W-1:0] cnt, div, pend_div;
    logic             pend_en, wrap, apply;
    assign wrap    = active && cnt == div - 1'b1;
    assign apply   = pending && (sync || !active || wrap);
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            div      <= CNT_W'(1);
            active   <= 1'b0;
            pending  <= 1'b0;
            pend_div <= CNT_W'(1);
            pend_en  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            if (load) begin
                pending  <= 1'b1;
                pend_div <= (cfg_div == '0) ? CNT_W'(1) : cfg_div;
                pend_en  <= cfg_en;
            end else if (apply) pending <= 1'b0;
            if (apply) begin
                div    <= pend_div;
                active <= pend_en;
            end
            // a wrap that disables the channel ends its final period without a strobe
            tick <= !sync && wrap && (!pending || pend_en);
            cnt  <= (sync || wrap || !active) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/tick_sched.sv
// tick_sched: NUM_CH independent clock-enable tick generators with handshaked config and global sync
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]          cfg_div,
    input  logic                      cfg_en,
    input  logic                      sync,
    output logic [NUM_CH-1:0]         tick_out,
    output logic [NUM_CH-1:0]         ch_active,
    output logic [NUM_CH-1:0]         cfg_pending
);
    localparam int CH_W = ch_w(NUM_CH);
    localparam int PW   = 2 ** CH_W;
    logic [PW-1:0] pend_pad;
    // out-of-range indices land on zero padding, so they always look ready
    assign pend_pad  = PW'(cfg_pending);
    assign cfg_ready = ~pend_pad[cfg_ch];
    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            tick_chan #(.CNT_W(CNT_W)) u_chan (
                .clk_in  (clk_in),
                .rst_n   (rst_n),
                .sync    (sync),
                .load    (cfg_valid && cfg_ready && cfg_ch == CH_W'(i)),
                .cfg_div (cfg_div),
                .cfg_en  (cfg_en),
                .tick    (tick_out[i]),
                .active  (ch_active[i]),
                .pending (cfg_pending[i])
            );
        end
    endgenerate
endmodule
